time_display_driver: RTL and testbench
======================================

# time_display_driver

Downstream consumer of the clock counter's `time_bus`. It snapshots the packed hours/minutes/seconds word once per scan frame and converts each field to two BCD digits. It drives a six-digit, common-anode, time-multiplexed 7-segment display, with per-field blanking (blink) for set mode. It sits between the time counter block and the board's display pins.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clocks per digit slot; minimum 2.
- `BLINK_DIV`, 12500000: clocks per blink half-period; minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `time_bus`  in  24  packed time, fields as follows; padding bits are ignored.
  - `[20:16]` hours.
  - `[13:8]` minutes.
  - `[5:0]` seconds.
- `blink_mask`  in  3  field blink enable, `{hours, minutes, seconds}`.
- `an_n`  out  6  digit anodes, active-low one-hot; bit 0 is the rightmost digit.
- `seg_n`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_n`  out  1  decimal point, active-low.

## Operation
- **Prescaler `pre`**
  - Counts 0..SCAN_DIV-1 and wraps.
  - When `pre == SCAN_DIV-1`, digit index `idx` advances on the next edge: 0→1→…→5→0.
- **Digit mapping**
  - idx0 = seconds ones, idx1 = seconds tens.
  - idx2 = minutes ones, idx3 = minutes tens.
  - idx4 = hours ones, idx5 = hours tens.
  - `an_n[idx]` is the active anode.
- **Snapshot**
  - The 24-bit `snap` register loads `time_bus` on the same edge that moves `idx` from 5 to 0.
  - Digits are never sourced from `time_bus` directly, so no frame mixes two times.
- **BCD conversion** (per field, combinational from `snap`)
  - tens = value / 10, ones = value % 10.
  - Invalid field (hours > 23, minutes > 59 or seconds > 59): both digits of that field show a dash (segment g only).
- **Segment codes**
  - 0..9 use standard codes, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Dash = 7'b0111111; blank = 7'b1111111.
- **Decimal point:** `dp_n` is low while idx is 2 or 4 (hh.mm.ss separators) and the digit is not blanked.
- **Blink**
  - Counter `bcnt` runs 0..BLINK_DIV-1; `phase` toggles at each wrap.
  - While `blink_mask == 0`, `bcnt` and `phase` are held at 0, so blinking always starts in the visible phase.
  - When `phase == 1` and the current digit's field bit is set, that digit is blanked: `an_n` all ones, `seg_n` blank, `dp_n` high.
- **Ghost guard:** in every cycle where `pre == 0`, `an_n` is all ones.

## Timing
- Reset values:
  - `an_n` = 6'b111111, `seg_n` = 7'h7F, `dp_n` = 1.
  - `pre`, `idx`, `bcnt`, `phase` = 0.
  - `snap` = 0, so 00.00.00 shows until the first frame wrap.
- All outputs are registered and computed from current-cycle state (`pre`, `idx`, `snap`, `phase`, `blink_mask`). Outputs lag state by exactly one clock.
- Digit slot length: SCAN_DIV clocks, of which the first is anode-off. Frame length: 6·SCAN_DIV.
- `time_bus` to display latency: at most 6·SCAN_DIV + 1 clocks; change takes effect at the next frame boundary.
- `blink_mask` changes take effect on the next clock. There is no resynchronisation; the input is assumed to come from the same clock domain.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronous). Scanning restarts at idx0 after release.

## Structure
- Package `time_disp_pkg` holds:
  - segment constants SEG_DIGIT[0:9], SEG_DASH, SEG_BLANK;
  - NUM_DIGITS = 6;
  - field limits HOUR_MAX = 23, MIN_SEC_MAX = 59;
  - the `time_bus` field bit positions.
- One sub-module, `field_to_bcd`:
  - Input: 6-bit value.
  - Parameter: LIMIT.
  - Outputs: tens[3:0], ones[3:0], valid.
  - Instantiated three times.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=8.
- **Reset:** hold `rst` low for 3 clocks, then release.
  - During reset: `an_n` = 111111, `seg_n` = 7'h7F, `dp_n` = 1.
  - First visible digit: `an_n` = 111110, `seg_n` = 7'b1000000.
- **Snapshot and decode:** `time_bus` = {3'b0, 5'd13, 2'b0, 6'd45, 2'b0, 6'd07}, run 2 frames.
  - Second frame shows digits 7, 0, 5, 4, 3, 1 on idx0..5.
  - `dp_n` is low on idx2 and idx4.
- **No tearing:** change `time_bus` while idx = 3.
  - The current frame is unchanged.
  - The new value appears only after the 5→0 edge.
- **Invalid field:** hours = 5'd30.
  - idx4 and idx5 show 7'b0111111.
  - Minutes and seconds digits decode normally.
- **Blink:** `blink_mask` = 3'b010.
  - Minutes digits (idx2, idx3) are dark during `phase` = 1 windows of 8 clocks and visible during `phase` = 0.
  - Clearing the mask restores the digits on the next clock.
- **Ghost guard:** in every digit slot, `an_n` = 111111 for exactly 1 clock, then one-hot for 3 clocks.

Source files
------------

// File: rtl/time_disp_pkg.sv
// Shared constants for the six-digit multiplexed time display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package time_disp_pkg;

    localparam int NUM_DIGITS  = 6;
    localparam int HOUR_MAX    = 23;
    localparam int MIN_SEC_MAX = 59;

    localparam int HR_MSB  = 20;
    localparam int HR_LSB  = 16;
    localparam int MIN_MSB = 13;
    localparam int MIN_LSB = 8;
    localparam int SEC_MSB = 5;
    localparam int SEC_LSB = 0;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/field_to_bcd.sv
// Splits a 0..63 time field into tens/ones digits.
// valid drops when the field exceeds LIMIT.
module field_to_bcd #(
    parameter int LIMIT = 59
) (
    input  logic [5:0] i_value,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_valid
);

    // Divide by ten via threshold compare; quotient never exceeds 6
    always_comb begin
        o_tens = 4'd0;
        o_ones = i_value[3:0];
        for (int t = 1; t < 7; t++) begin
            if (i_value >= 6'(t * 10)) begin
                o_tens = 4'(t);
                o_ones = 4'(i_value - 6'(t * 10));
            end
        end
    end

    assign o_valid = (i_value <= 6'(LIMIT));

endmodule

// File: rtl/time_display_driver.sv
// Scans hh.mm.ss onto a six-digit common-anode display.
// time_bus is snapshotted once per frame so a frame never tears.
module time_display_driver
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_bus,
    input  logic [2:0]  blink_mask,
    output logic [5:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_idx;
    logic [23:0]      r_snap;
    logic [BLK_W-1:0] r_bcnt;
    logic             r_phase;
    disp_t            r_out;

    logic       w_pre_wrap;
    logic [3:0] w_h_ten, w_h_one, w_m_ten, w_m_one, w_s_ten, w_s_one;
    logic       w_h_ok, w_m_ok, w_s_ok;
    logic [6:0] w_code;
    logic       w_fbit;
    logic       w_blank;
    disp_t      w_next;
    logic       w_unused;

    assign w_pre_wrap = (r_pre == PRE_W'(SCAN_DIV - 1));
    assign w_unused   = ^{r_snap[23:21], r_snap[15:14], r_snap[7:6]};

    field_to_bcd #(.LIMIT(HOUR_MAX)) u_hours (
        .i_value ({1'b0, r_snap[HR_MSB:HR_LSB]}),
        .o_tens  (w_h_ten),
        .o_ones  (w_h_one),
        .o_valid (w_h_ok)
    );

    field_to_bcd #(.LIMIT(MIN_SEC_MAX)) u_minutes (
        .i_value (r_snap[MIN_MSB:MIN_LSB]),
        .o_tens  (w_m_ten),
        .o_ones  (w_m_one),
        .o_valid (w_m_ok)
    );

    field_to_bcd #(.LIMIT(MIN_SEC_MAX)) u_seconds (
        .i_value (r_snap[SEC_MSB:SEC_LSB]),
        .o_tens  (w_s_ten),
        .o_ones  (w_s_one),
        .o_valid (w_s_ok)
    );

    // Slot prescaler, digit index and per-frame snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre  <= '0;
            r_idx  <= 3'd0;
            r_snap <= 24'd0;
        end else if (w_pre_wrap) begin
            r_pre <= '0;
            if (r_idx == 3'(NUM_DIGITS - 1)) begin
                r_idx  <= 3'd0;
                r_snap <= time_bus;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Blink timebase, parked in the visible phase while no field blinks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (blink_mask == 3'b000) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == BLK_W'(BLINK_DIV - 1)) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    // Pick the segment code and blink bit for the current digit
    always_comb begin
        w_code = SEG_BLANK;
        w_fbit = 1'b0;
        case (r_idx)
            3'd0: begin
                w_code = w_s_ok ? seg_of(w_s_one) : SEG_DASH;
                w_fbit = blink_mask[0];
            end
            3'd1: begin
                w_code = w_s_ok ? seg_of(w_s_ten) : SEG_DASH;
                w_fbit = blink_mask[0];
            end
            3'd2: begin
                w_code = w_m_ok ? seg_of(w_m_one) : SEG_DASH;
                w_fbit = blink_mask[1];
            end
            3'd3: begin
                w_code = w_m_ok ? seg_of(w_m_ten) : SEG_DASH;
                w_fbit = blink_mask[1];
            end
            3'd4: begin
                w_code = w_h_ok ? seg_of(w_h_one) : SEG_DASH;
                w_fbit = blink_mask[2];
            end
            3'd5: begin
                w_code = w_h_ok ? seg_of(w_h_ten) : SEG_DASH;
                w_fbit = blink_mask[2];
            end
            default: begin
            end
        endcase
    end

    assign w_blank = r_phase & w_fbit;

    // Next pin state: ghost guard on slot start, blanking, separators
    always_comb begin
        w_next.an  = 6'h3F;
        w_next.seg = w_code;
        w_next.dp  = 1'b1;
        if (w_blank) begin
            w_next.seg = SEG_BLANK;
        end else begin
            if (r_pre != '0) begin
                w_next.an = ~(6'b000001 << r_idx);
            end
            w_next.dp = ~((r_idx == 3'd2) || (r_idx == 3'd4));
        end
    end

    // Register the pins so they never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '{an: 6'h3F, seg: SEG_BLANK, dp: 1'b1};
        end else begin
            r_out <= w_next;
        end
    end

    assign an_n  = r_out.an;
    assign seg_n = r_out.seg;
    assign dp_n  = r_out.dp;

endmodule

// File: tb/tb_time_display_driver.sv
// Bench for time_display_driver with SCAN_DIV=4, BLINK_DIV=8.
// Expected pins come from constant digit tables and cycle position.
module tb_time_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] time_bus = 24'd0;
    logic [2:0]  blink_mask = 3'd0;
    logic [5:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    time_display_driver #(
        .SCAN_DIV  (4),
        .BLINK_DIV (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .time_bus   (time_bus),
        .blink_mask (blink_mask),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]     tb;
        logic [5:0][6:0] seg;
    } vec_t;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam logic [6:0] D = 7'b0111111;

    vec_t tbl [5];
    exp_t q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur = 0;
    int snp = 0;
    int bstart = 0;
    logic [2:0] m_mask = 3'd0;

    function automatic exp_t expect_now();
        exp_t e;
        int pre, idx;
        logic blank;
        pre = cyc % 4;
        idx = (cyc / 4) % 6;
        blank = m_mask[idx / 2] && ((((cyc - bstart) / 8) % 2) == 1);
        e.an  = (pre == 0 || blank) ? 6'h3F : ~(6'd1 << idx);
        e.seg = blank ? 7'h7F : tbl[snp].seg[idx];
        e.dp  = ((idx == 2 || idx == 4) && !blank) ? 1'b0 : 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        checks++;
        if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp) begin
            errors++;
            $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                     name, cyc, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
        end
    endtask

    task automatic drive(input int i);
        cur = i;
        time_bus = tbl[i].tb;
    endtask

    task automatic run(input int n, input string name);
        for (int j = 0; j < n; j++) begin
            q.push_back(expect_now());
            @(posedge clk);
            #1;
            check(name, q.pop_front());
            if (cyc % 24 == 23) snp = cur;
            cyc++;
        end
    endtask

    task automatic release_rst();
        rst = 1'b1;
        cyc = 0;
        snp = 0;
        m_mask = 3'd0;
        bstart = 0;
    endtask

    initial begin
        exp_t rexp;
        rexp = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1};

        tbl[0].tb  = 24'd0;
        tbl[0].seg = {6{7'b1000000}};
        tbl[1].tb  = {3'b0, 5'd13, 2'b0, 6'd45, 2'b0, 6'd7};
        tbl[1].seg = {7'b1111001, 7'b0110000, 7'b0011001,
                      7'b0010010, 7'b1000000, 7'b1111000};
        tbl[2].tb  = {3'b0, 5'd30, 2'b0, 6'd59, 2'b0, 6'd59};
        tbl[2].seg = {D, D, 7'b0010010, 7'b0010000,
                      7'b0010010, 7'b0010000};
        tbl[3].tb  = {3'b0, 5'd23, 2'b0, 6'd0, 2'b0, 6'd60};
        tbl[3].seg = {7'b0100100, 7'b0110000, 7'b1000000,
                      7'b1000000, D, D};
        tbl[4].tb  = {3'b111, 5'd8, 2'b11, 6'd26, 2'b11, 6'd31};
        tbl[4].seg = {7'b1000000, 7'b0000000, 7'b0100100,
                      7'b0000010, 7'b0110000, 7'b1111001};

        drive(0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset", rexp);
        end
        release_rst();

        for (int i = 1; i < 5; i++) begin
            drive(i);
            run(24, "table");
        end
        run(24, "table_last");

        drive(1);
        run(13, "tear_pre");
        drive(2);
        run(11, "tear_hold");
        run(24, "tear_new");

        drive(1);
        run(24, "load");
        m_mask = 3'b010;
        blink_mask = 3'b010;
        bstart = cyc;
        run(58, "blink_min");
        m_mask = 3'b000;
        blink_mask = 3'b000;
        run(24, "unblink");
        m_mask = 3'b101;
        blink_mask = 3'b101;
        bstart = cyc;
        run(48, "blink_hs");

        run(5, "pre_rst");
        rst = 1'b0;
        #1;
        check("async_rst", rexp);
        m_mask = 3'b000;
        blink_mask = 3'b000;
        @(posedge clk);
        #1;
        check("rst_hold", rexp);
        release_rst();
        drive(3);
        run(48, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
